// File: rtl/jtag_bridge_pkg.sv
// jtag_bridge_pkg
//   Shared definitions for the JTAG shift bridge: FSM state encoding and the
//   bit offsets of the fields inside the user data register.
//   DR layout (LSB first): wr | ack | channel | payload | [parity]
package jtag_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SHIFT    = 2'd1,
      ST_WAIT_UPD = 2'd2
   } state_t;

   localparam int WR_BIT   = 0;
   localparam int ACK_BIT  = 1;
   localparam int CHAN_LSB = 2;

   function automatic int data_lsb(input int chan_bits);
      return CHAN_LSB + chan_bits;
   endfunction

   function automatic int dr_width(input int chan_bits, input int data_width, input int par_bits);
      return data_lsb(chan_bits) + data_width + par_bits;
   endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge
//   Brings one asynchronous JTAG control signal into the clk_i domain through
//   a SYNC_STAGES flop chain and flags its rising edge.
//   Ports:
//     clk_i, rst_i  system clock, async active-high reset
//     async_in      raw TAP signal
//     level         synchronised level
//     rise          one-cycle pulse on a synchronised 0->1 transition
module jtag_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_in,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] pipe;
   logic                   prev;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pipe <= '0;
         prev <= 1'b0;
      end else begin
         pipe <= {pipe[SYNC_STAGES-2:0], async_in};
         prev <= pipe[SYNC_STAGES-1];
      end
   end

   assign level = pipe[SYNC_STAGES-1];
   assign rise  = level & ~prev;

endmodule

// File: rtl/jtag_shift_bridge.sv
// jtag_shift_bridge
//   JTAG user-DR to core message bridge. Oversamples the chain TAP signals in
//   the clk_i domain, shifts a DR of wr/ack/channel/payload and exchanges one
//   word each way with the core over valid/ready.
//   Optional feature macro: JTAG_SHIFT_BRIDGE_PARITY_EN (MSB even-parity bit).
//   Ports:
//     clk_i, rst_i                 system clock, async active-high reset
//     jtag_tck/tdi/shift/update/reset  TAP outputs (async to clk_i)
//     jtag_tdo                     DR bit 0 back to the TAP
//     rx_valid/rx_ready/rx_chan/rx_data  host-to-core word
//     tx_valid/tx_ready/tx_chan/tx_data  core-to-host word
//     rx_overflow                  sticky: host wrote while rx word pending
//     parity_err                   sticky: frame failed parity (0 without macro)
//
//   state       | meaning
//   ST_IDLE     | waiting for shift to start; capture frame loaded on entry to SHIFT
//   ST_SHIFT    | shifting sr on every synced TCK rising edge
//   ST_WAIT_UPD | shift done; commit on update, or recapture on a new shift
module jtag_shift_bridge
   import jtag_bridge_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int CHAN_BITS   = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  jtag_tck,
   input  logic                  jtag_tdi,
   input  logic                  jtag_shift,
   input  logic                  jtag_update,
   input  logic                  jtag_reset,
   output logic                  jtag_tdo,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic [CHAN_BITS-1:0]  rx_chan,
   output logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [CHAN_BITS-1:0]  tx_chan,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  rx_overflow,
   output logic                  parity_err
);

`ifdef JTAG_SHIFT_BRIDGE_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int DLSB = data_lsb(CHAN_BITS);
   localparam int W    = dr_width(CHAN_BITS, DATA_WIDTH, PAR_BITS);

   state_t                 state;
   logic [W-1:0]           sr;
   logic [W-1:0]           cap_frame;
   logic                   tx_full;
   logic [CHAN_BITS-1:0]   tx_chan_q;
   logic [DATA_WIDTH-1:0]  tx_data_q;

   logic tck_lvl, tck_rise, shift_lvl, shift_rise;
   logic upd_lvl, upd_rise, rst_lvl, rst_rise;
   logic [SYNC_STAGES-1:0] tdi_pipe;
   logic tdi_s;
   logic commit, frame_ok;
   logic unused_sync;

   jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tck (
      .clk_i(clk_i), .rst_i(rst_i), .async_in(jtag_tck), .level(tck_lvl), .rise(tck_rise));
   jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_shift (
      .clk_i(clk_i), .rst_i(rst_i), .async_in(jtag_shift), .level(shift_lvl), .rise(shift_rise));
   jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_update (
      .clk_i(clk_i), .rst_i(rst_i), .async_in(jtag_update), .level(upd_lvl), .rise(upd_rise));
   jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_reset (
      .clk_i(clk_i), .rst_i(rst_i), .async_in(jtag_reset), .level(rst_lvl), .rise(rst_rise));

   assign unused_sync = &{1'b0, tck_lvl, upd_lvl, rst_rise};

   // Same depth as the tck path, so tdi_s is aligned with tck_rise.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) tdi_pipe <= '0;
      else       tdi_pipe <= {tdi_pipe[SYNC_STAGES-2:0], jtag_tdi};
   end
   assign tdi_s = tdi_pipe[SYNC_STAGES-1];

   always_comb begin
      cap_frame          = '0;
      cap_frame[WR_BIT]  = rx_valid;
      cap_frame[ACK_BIT] = tx_full;
      if (tx_full) begin
         cap_frame[CHAN_LSB +: CHAN_BITS] = tx_chan_q;
         cap_frame[DLSB +: DATA_WIDTH]    = tx_data_q;
      end
`ifdef JTAG_SHIFT_BRIDGE_PARITY_EN
      cap_frame[W-1] = ^cap_frame[W-2:0];
`endif
   end

`ifdef JTAG_SHIFT_BRIDGE_PARITY_EN
   assign frame_ok = ~(^sr);
`else
   assign frame_ok = 1'b1;
`endif

   // A shift edge arriving together with update wins: recapture, no commit.
   assign commit   = (state == ST_WAIT_UPD) && upd_rise && !shift_rise && !rst_lvl;
   assign tx_ready = ~tx_full;
   assign jtag_tdo = sr[0];

`ifndef JTAG_SHIFT_BRIDGE_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         sr          <= '0;
         rx_valid    <= 1'b0;
         rx_chan     <= '0;
         rx_data     <= '0;
         rx_overflow <= 1'b0;
         tx_full     <= 1'b0;
         tx_chan_q   <= '0;
         tx_data_q   <= '0;
`ifdef JTAG_SHIFT_BRIDGE_PARITY_EN
         parity_err  <= 1'b0;
`endif
      end else begin
         if (rx_valid && rx_ready) rx_valid <= 1'b0;

         if (commit && frame_ok) begin
            if (sr[WR_BIT]) begin
               if (rx_valid) begin
                  rx_overflow <= 1'b1;
               end else begin
                  rx_valid <= 1'b1;
                  rx_chan  <= sr[CHAN_LSB +: CHAN_BITS];
                  rx_data  <= sr[DLSB +: DATA_WIDTH];
               end
            end
            if (sr[ACK_BIT]) tx_full <= 1'b0;
         end
`ifdef JTAG_SHIFT_BRIDGE_PARITY_EN
         if (commit && !frame_ok) parity_err <= 1'b1;
`endif

         // Placed after the ack so a load into an empty register is never lost.
         if (tx_valid && !tx_full) begin
            tx_full   <= 1'b1;
            tx_chan_q <= tx_chan;
            tx_data_q <= tx_data;
         end

         if (rst_lvl) begin
            state <= ST_IDLE;
            sr    <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (shift_rise) begin
                     sr    <= cap_frame;
                     state <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  if (tck_rise)   sr    <= {tdi_s, sr[W-1:1]};
                  if (!shift_lvl) state <= ST_WAIT_UPD;
               end
               ST_WAIT_UPD: begin
                  if (shift_rise) begin
                     sr    <= cap_frame;
                     state <= ST_SHIFT;
                  end else if (upd_rise) begin
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtag_shift_bridge.sv
// tb_jtag_shift_bridge
//   Drives complete JTAG DR frames and core-side handshakes against
//   jtag_shift_bridge and compares every observable against a
//   transaction-level model of the host/core mailboxes.
//   Honours JTAG_SHIFT_BRIDGE_PARITY_EN when the DUT is built with it.
module tb_jtag_shift_bridge;

   localparam int DW   = 8;
   localparam int CB   = 2;
   localparam int SS   = 2;
`ifdef JTAG_SHIFT_BRIDGE_PARITY_EN
   localparam int PB   = 1;
`else
   localparam int PB   = 0;
`endif
   localparam int W    = 2 + CB + DW + PB;
   localparam int HALF = SS + 3;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic jtag_tck = 1'b0, jtag_tdi = 1'b0, jtag_shift = 1'b0;
   logic jtag_update = 1'b0, jtag_reset = 1'b0;
   logic jtag_tdo;
   logic rx_valid, rx_ready = 1'b0;
   logic [CB-1:0] rx_chan;
   logic [DW-1:0] rx_data;
   logic tx_valid = 1'b0, tx_ready;
   logic [CB-1:0] tx_chan = '0;
   logic [DW-1:0] tx_data = '0;
   logic rx_overflow, parity_err;

   int n_checks = 0;
   int n_errors = 0;

   // mailbox model
   logic          m_rx_valid, m_ovf, m_perr, m_tx_full;
   logic [CB-1:0] m_rx_chan, m_tx_chan;
   logic [DW-1:0] m_rx_data, m_tx_data;

   jtag_shift_bridge #(.DATA_WIDTH(DW), .CHAN_BITS(CB), .SYNC_STAGES(SS)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .jtag_tck(jtag_tck), .jtag_tdi(jtag_tdi), .jtag_shift(jtag_shift),
      .jtag_update(jtag_update), .jtag_reset(jtag_reset), .jtag_tdo(jtag_tdo),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_chan(rx_chan), .rx_data(rx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_chan(tx_chan), .tx_data(tx_data),
      .rx_overflow(rx_overflow), .parity_err(parity_err));

   always #5 clk_i = ~clk_i;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Frame value built arithmetically from its fields; parity makes the
   // total number of ones even.
   function automatic logic [W-1:0] mk_frame(input int b0, input int b1, input int chan, input int data);
      longint v;
      logic [W-1:0] f;
      v = longint'(b0) + 2 * longint'(b1) + 4 * longint'(chan) + longint'(data) * (longint'(1) << (2 + CB));
      f = v[W-1:0];
      if (PB == 1) f[W-1] = ($countones(v) % 2 == 1);
      return f;
   endfunction

   function automatic logic [W-1:0] exp_capture();
      if (m_tx_full) return mk_frame(int'(m_rx_valid), 1, int'(m_tx_chan), int'(m_tx_data));
      return mk_frame(int'(m_rx_valid), 0, 0, 0);
   endfunction

   task automatic model_reset();
      m_rx_valid = 1'b0; m_ovf = 1'b0; m_perr = 1'b0; m_tx_full = 1'b0;
      m_rx_chan = '0; m_tx_chan = '0; m_rx_data = '0; m_tx_data = '0;
   endtask

   task automatic model_commit(input logic [W-1:0] f);
      longint fv;
      int wr, ack;
      fv  = longint'(f);
      wr  = int'(fv % 2);
      ack = int'((fv / 2) % 2);
      if (PB == 1 && ($countones(fv) % 2 == 1)) begin
         m_perr = 1'b1;
         return;
      end
      if (wr == 1) begin
         if (m_rx_valid) m_ovf = 1'b1;
         else begin
            m_rx_valid = 1'b1;
            m_rx_chan  = CB'((fv / 4) % (1 << CB));
            m_rx_data  = DW'((fv / (1 << (2 + CB))) % (1 << DW));
         end
      end
      if (ack == 1) m_tx_full = 1'b0;
   endtask

   task automatic check_outputs(input string where);
      chk({where, ":rx_valid"},    64'(rx_valid),    64'(m_rx_valid));
      chk({where, ":rx_chan"},     64'(rx_chan),     64'(m_rx_chan));
      chk({where, ":rx_data"},     64'(rx_data),     64'(m_rx_data));
      chk({where, ":rx_overflow"}, 64'(rx_overflow), 64'(m_ovf));
      chk({where, ":tx_ready"},    64'(tx_ready),    64'(!m_tx_full));
      chk({where, ":parity_err"},  64'(parity_err),  64'(m_perr));
   endtask

   task automatic shift_bit(input logic b, output logic t);
      jtag_tdi = b;
      clks(HALF);
      t = jtag_tdo;
      jtag_tck = 1'b1;
      clks(HALF);
      jtag_tck = 1'b0;
   endtask

   task automatic jtag_frame(input logic [W-1:0] upd, output logic [W-1:0] cap);
      logic t;
      jtag_shift = 1'b1;
      clks(HALF);
      for (int i = 0; i < W; i++) begin
         shift_bit(upd[i], t);
         cap[i] = t;
      end
      clks(HALF);
      jtag_shift = 1'b0;
      clks(HALF);
      jtag_update = 1'b1;
      clks(HALF);
      jtag_update = 1'b0;
      clks(HALF);
   endtask

   task automatic host_send(input string tag, input logic [W-1:0] upd);
      logic [W-1:0] cap, exp;
      exp = exp_capture();
      jtag_frame(upd, cap);
      chk({tag, ":capture"}, 64'(cap), 64'(exp));
      model_commit(upd);
      check_outputs(tag);
   endtask

   task automatic core_load(input string tag, input int chan, input int data);
      tx_chan  = CB'(chan);
      tx_data  = DW'(data);
      tx_valid = 1'b1;
      clks(1);
      tx_valid = 1'b0;
      if (!m_tx_full) begin
         m_tx_full = 1'b1;
         m_tx_chan = CB'(chan);
         m_tx_data = DW'(data);
      end
      clks(1);
      check_outputs(tag);
   endtask

   task automatic core_drain(input string tag);
      rx_ready = 1'b1;
      clks(1);
      rx_ready = 1'b0;
      m_rx_valid = 1'b0;
      check_outputs(tag);
   endtask

   initial begin
      logic t;
      logic [W-1:0] f;
      model_reset();
      clks(3);
      rst_i = 1'b0;
      clks(2);
      check_outputs("reset");
      chk("reset:tdo", 64'(jtag_tdo), 64'd0);

      // write then drain
      host_send("write", mk_frame(1, 0, 2, 'hA5));
      chk("write:chan2", 64'(rx_chan), 64'd2);
      chk("write:dataA5", 64'(rx_data), 64'hA5);
      core_drain("drain");

      // overflow keeps the first word
      host_send("ovf1", mk_frame(1, 0, 0, 'h11));
      host_send("ovf2", mk_frame(1, 0, 3, 'h22));
      chk("ovf:data11", 64'(rx_data), 64'h11);
      chk("ovf:sticky", 64'(rx_overflow), 64'd1);
      core_drain("ovf_drain");

      // read path: capture shows the tx word until acked
      core_load("load", 1, 'h3C);
      chk("load:tx_ready0", 64'(tx_ready), 64'd0);
      host_send("read", mk_frame(0, 0, 0, 0));
      host_send("ack", mk_frame(0, 1, 0, 0));
      chk("ack:tx_ready1", 64'(tx_ready), 64'd1);

      // abort mid-shift with jtag_reset
      f = mk_frame(1, 0, 1, 'h77);
      jtag_shift = 1'b1;
      clks(HALF);
      for (int i = 0; i < 5; i++) shift_bit(f[i], t);
      jtag_reset = 1'b1;
      clks(HALF);
      jtag_reset = 1'b0;
      jtag_shift = 1'b0;
      clks(HALF);
      jtag_update = 1'b1;
      clks(HALF);
      jtag_update = 1'b0;
      clks(HALF);
      check_outputs("abort");
      host_send("after_abort", mk_frame(1, 0, 1, 'h5A));
      core_drain("after_abort_drain");

`ifdef JTAG_SHIFT_BRIDGE_PARITY_EN
      f = mk_frame(1, 0, 0, 'h55);
      f[W-1] = ~f[W-1];
      host_send("par_bad", f);
      chk("par_bad:err", 64'(parity_err), 64'd1);
      host_send("par_good", mk_frame(1, 0, 0, 'h55));
      core_drain("par_drain");
`endif

      // randomized traffic
      for (int k = 0; k < 30; k++) begin
         case ($urandom_range(0, 2))
            0: host_send("rnd_frame", mk_frame(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                                               int'($urandom_range(0, (1 << CB) - 1)),
                                               int'($urandom_range(0, (1 << DW) - 1))));
            1: core_load("rnd_load", int'($urandom_range(0, (1 << CB) - 1)),
                         int'($urandom_range(0, (1 << DW) - 1)));
            default: core_drain("rnd_drain");
         endcase
      end

      // async reset while shifting with a pending rx word
      host_send("pre_rst", mk_frame(1, 0, 3, 'hC3));
      if (!m_rx_valid) core_drain("pre_rst_drain");
      if (!m_rx_valid) host_send("pre_rst2", mk_frame(1, 0, 3, 'hC3));
      core_load("pre_rst_load", 2, 'h81);
      jtag_shift = 1'b1;
      clks(HALF);
      for (int i = 0; i < 3; i++) shift_bit(1'b1, t);
      #3;
      rst_i = 1'b1;
      #1;
      model_reset();
      check_outputs("async_rst");
      chk("async_rst:tdo", 64'(jtag_tdo), 64'd0);
      jtag_shift = 1'b0;
      jtag_tdi   = 1'b0;
      clks(3);
      rst_i = 1'b0;
      clks(2);
      host_send("post_rst", mk_frame(1, 0, 1, 'h42));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
